// File: rtl/fp_accum_mc_if.sv
// Operand/result bundle for the multi-channel FP accumulator.
// The master drives operands and clears; the slave returns ready, results and sticky flags.
interface fp_accum_mc_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic              in_vld;
  logic              in_rdy;
  logic [CH_W-1:0]   in_ch;
  logic              in_op;
  logic [31:0]       in_value;
  logic              clr;
  logic [CH_W-1:0]   clr_ch;
  logic              res_vld;
  logic [CH_W-1:0]   res_ch;
  logic [31:0]       res;
  logic              res_exc;
  logic [NUM_CH-1:0] exc_sticky;

  modport master (
    output in_vld, in_ch, in_op, in_value, clr, clr_ch,
    input  in_rdy, res_vld, res_ch, res, res_exc, exc_sticky
  );

  modport slave (
    input  in_vld, in_ch, in_op, in_value, clr, clr_ch,
    output in_rdy, res_vld, res_ch, res, res_exc, exc_sticky
  );
endinterface

// File: rtl/fp_accum_mc.sv
// NUM_CH independent single-precision accumulators sharing one combinational add/sub core.
// The adder result is computed at accept time and retimed over PIPE stages before writeback.
module fp_accum_mc #(
  parameter int NUM_CH = 4,
  parameter int PIPE   = 2
) (
  input logic          clk,
  input logic          rst,
  fp_accum_mc_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);

  // Round-to-nearest-even add/sub; returns {exception, result}. b is negated when sub=1.
  function automatic logic [32:0] fp_add(input logic [31:0] a, input logic [31:0] b,
                                         input logic sub);
    logic [31:0] bb, x, y;
    logic        sx, sy, eff_sub, special, up;
    logic [7:0]  ex, ey, d;
    logic [23:0] mx, my, mf;
    logic [49:0] x50, y50, n;
    logic [50:0] s;
    logic [5:0]  lz;
    logic [9:0]  sh, en;
    logic [24:0] mr;
    logic [32:0] out;
    bb = {b[31] ^ sub, b[30:0]};
    if (bb[30:0] > a[30:0]) begin
      x = bb;
      y = a;
    end else begin
      x = a;
      y = bb;
    end
    sx      = x[31];
    sy      = y[31];
    eff_sub = sx ^ sy;
    special = &x[30:23];
    ex      = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey      = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx      = {|x[30:23], x[22:0]};
    my      = {|y[30:23], y[22:0]};
    d       = ex - ey;
    x50     = {mx, 26'd0};
    // Beyond 26 bits of alignment the smaller operand only matters as a sticky bit.
    y50     = (d > 8'd26) ? {49'd0, |my} : ({my, 26'd0} >> d);
    s       = eff_sub ? ({1'b0, x50} - {1'b0, y50}) : ({1'b0, x50} + {1'b0, y50});
    lz      = 6'd50;
    for (int unsigned i = 0; i < 50; i++) begin
      if (s[i]) lz = 6'(49 - i);
    end
    sh = '0;
    if (s[50]) begin
      n  = {s[50:2], s[1] | s[0]};
      en = {2'd0, ex} + 10'd1;
    end else begin
      // Normalisation stops at the minimum exponent, leaving a subnormal.
      sh = ({4'd0, lz} < ({2'd0, ex} - 10'd1)) ? {4'd0, lz} : ({2'd0, ex} - 10'd1);
      n  = s[49:0] << sh;
      en = {2'd0, ex} - sh;
    end
    up = n[25] & ((|n[24:0]) | n[26]);
    mr = {1'b0, n[49:26]} + {24'd0, up};
    if (mr[24]) begin
      mf = mr[24:1];
      en = en + 10'd1;
    end else begin
      mf = mr[23:0];
    end
    if (special)
      out = {1'b1, ((|x[22:0]) || (eff_sub && (&y[30:23]))) ? 32'h7FC0_0000 : {sx, 8'hFF, 23'd0}};
    else if (s == 51'd0)
      out = {1'b0, sx & sy, 31'd0};
    else if (en >= 10'd255)
      out = {1'b1, sx, 8'hFF, 23'd0};
    else
      out = {1'b0, sx, mf[23] ? en[7:0] : 8'd0, mf[22:0]};
    return out;
  endfunction

  logic [31:0]       acc [NUM_CH];
  logic [NUM_CH-1:0] sticky;
  logic [PIPE-1:0]   st_vld;
  logic [PIPE-1:0]   st_exc;
  logic [CH_W-1:0]   st_ch  [PIPE];
  logic [31:0]       st_res [PIPE];
  logic [32:0]       add_out;
  logic              rdy, accept, ret_vld;
  logic              res_vld_q, res_exc_q;
  logic [CH_W-1:0]   res_ch_q;
  logic [31:0]       res_q;

  // Any in-flight entry for the channel blocks it, so the adder never sees a stale acc.
  always_comb begin
    rdy = !(bus.clr && (bus.clr_ch == bus.in_ch));
    for (int unsigned i = 0; i < PIPE; i++) begin
      if (st_vld[i] && (st_ch[i] == bus.in_ch)) rdy = 1'b0;
    end
  end

  assign add_out = fp_add(acc[bus.in_ch], bus.in_value, bus.in_op);
  assign accept  = bus.in_vld & rdy;
  assign ret_vld = st_vld[PIPE-1] && !(bus.clr && (st_ch[PIPE-1] == bus.clr_ch));

  assign bus.in_rdy     = rdy;
  assign bus.res_vld    = res_vld_q;
  assign bus.res_ch     = res_ch_q;
  assign bus.res        = res_q;
  assign bus.res_exc    = res_exc_q;
  assign bus.exc_sticky = sticky;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_vld <= '0;
      st_exc <= '0;
      for (int unsigned i = 0; i < PIPE; i++) begin
        st_ch[i]  <= '0;
        st_res[i] <= '0;
      end
    end else begin
      st_vld[0] <= accept;
      st_exc[0] <= add_out[32];
      st_ch[0]  <= bus.in_ch;
      st_res[0] <= add_out[31:0];
      for (int unsigned i = 1; i < PIPE; i++) begin
        st_vld[i] <= st_vld[i-1] && !(bus.clr && (st_ch[i-1] == bus.clr_ch));
        st_exc[i] <= st_exc[i-1];
        st_ch[i]  <= st_ch[i-1];
        st_res[i] <= st_res[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) acc[c] <= '0;
      sticky    <= '0;
      res_vld_q <= 1'b0;
      res_exc_q <= 1'b0;
      res_ch_q  <= '0;
      res_q     <= '0;
    end else begin
      res_vld_q <= ret_vld;
      if (ret_vld) begin
        res_q     <= st_res[PIPE-1];
        res_ch_q  <= st_ch[PIPE-1];
        res_exc_q <= st_exc[PIPE-1];
        if (st_exc[PIPE-1]) sticky[st_ch[PIPE-1]] <= 1'b1;
        else                acc[st_ch[PIPE-1]]    <= st_res[PIPE-1];
      end
      if (bus.clr) begin
        acc[bus.clr_ch]    <= '0;
        sticky[bus.clr_ch] <= 1'b0;
      end
    end
  end
endmodule
